// File: rtl/rf_write_arbiter.sv
// Arbitrates the register-file write port between the ALU and load writeback paths.
// Optional ALU anti-starvation guard enabled by defining RF_WARB_STARVE_GUARD_EN.
module rf_write_arbiter #(
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  output logic        alu_ready,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        reg_write,
  output logic [4:0]  rd,
  output logic [31:0] write_data,
  output logic        wr_src
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  logic alu_grant;
  logic ld_grant;

`ifdef RF_WARB_STARVE_GUARD_EN
  localparam logic [3:0] Limit = 4'(STARVE_LIMIT);

  logic [3:0] starve_d, starve_q;
  logic       guard;

  // Once the ALU has lost Limit times in a row it takes the port ahead of the load.
  assign guard = alu_valid && (starve_q == Limit);

  always_comb begin
    ld_grant  = ld_valid && !guard;
    alu_grant = alu_valid && (!ld_valid || guard);
    starve_d  = starve_q;
    if (!alu_valid || alu_grant) begin
      starve_d = 4'd0;
    end else if (ld_grant && (starve_q != Limit)) begin
      starve_d = starve_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q <= 4'd0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  always_comb begin
    ld_grant  = ld_valid;
    alu_grant = alu_valid && !ld_valid;
  end
`endif

  assign alu_ready = alu_grant && !rst;
  assign ld_ready  = ld_grant && !rst;

  logic        reg_write_d, reg_write_q;
  logic [4:0]  rd_d, rd_q;
  logic [31:0] data_d, data_q;
  logic        src_d, src_q;

  always_comb begin
    rd_d        = rd_q;
    data_d      = data_q;
    src_d       = src_q;
    reg_write_d = 1'b0;
    if (ld_grant) begin
      rd_d   = ld_rd;
      data_d = ld_data;
      src_d  = 1'b1;
    end else if (alu_grant) begin
      rd_d   = alu_rd;
      data_d = alu_data;
      src_d  = 1'b0;
    end
    // Writes to x0 are accepted but never reach the register file.
    if (ld_grant || alu_grant) begin
      reg_write_d = (rd_d != 5'd0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      data_q      <= 32'd0;
      src_q       <= 1'b0;
    end else begin
      reg_write_q <= reg_write_d;
      rd_q        <= rd_d;
      data_q      <= data_d;
      src_q       <= src_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = data_q;
  assign wr_src     = src_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter; follows RF_WARB_STARVE_GUARD_EN if defined.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid, ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        reg_write;
  logic [4:0]  rd;
  logic [31:0] write_data;
  logic        wr_src;

  int tests = 0;
  int fails = 0;

  rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_ready  (alu_ready),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .wr_src     (wr_src)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    tests++;
    if ({reg_write, rd, write_data, wr_src} !== 39'd0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b rd=%0d data=%h src=%b, want all 0",
               reg_write, rd, write_data, wr_src);
    end
    tests++;
    if ({alu_ready, ld_ready} !== 2'b00) begin
      fails++;
      $display("FAIL reset_readys: got alu=%b ld=%b, want 0 0", alu_ready, ld_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0; ld_rd = 5'd7; ld_data = 32'hA5A5_0007;
    @(negedge clk);
    tests++;
    if ({ld_ready, alu_ready} !== 2'b10) begin
      fails++;
      $display("FAIL release_readys: got ld=%b alu=%b, want 1 0", ld_ready, alu_ready);
    end
    @(posedge clk); #1;
    alu_valid = 1'b0; ld_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src, write_data} !== {1'b1, 5'd7, 1'b1, 32'hA5A5_0007}) begin
      fails++;
      $display("FAIL first_load: got we=%b rd=%0d src=%b data=%h, want 1 7 1 a5a50007",
               reg_write, rd, wr_src, write_data);
    end
  endtask

  task automatic test_single_alu();
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF; ld_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({alu_ready, ld_ready} !== 2'b10) begin
      fails++;
      $display("FAIL single_ready: got alu=%b ld=%b, want 1 0", alu_ready, ld_ready);
    end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src, write_data} !== {1'b1, 5'd5, 1'b0, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL single_write: got we=%b rd=%0d src=%b data=%h, want 1 5 0 deadbeef",
               reg_write, rd, wr_src, write_data);
    end
    @(posedge clk); #1;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, write_data} !== {1'b0, 5'd5, 32'hDEAD_BEEF}) begin
      fails++;
      $display("FAIL single_idle: got we=%b rd=%0d data=%h, want 0 5 deadbeef",
               reg_write, rd, write_data);
    end
  endtask

  task automatic test_contention();
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_AAAA;
    ld_valid  = 1'b1; ld_rd  = 5'd4; ld_data  = 32'h0000_BBBB;
    @(negedge clk);
    tests++;
    if ({ld_ready, alu_ready} !== 2'b10) begin
      fails++;
      $display("FAIL contend_ready: got ld=%b alu=%b, want 1 0", ld_ready, alu_ready);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src, write_data, alu_ready} !==
        {1'b1, 5'd4, 1'b1, 32'h0000_BBBB, 1'b1}) begin
      fails++;
      $display("FAIL contend_load: got we=%b rd=%0d src=%b data=%h alu_ready=%b, want 1 4 1 bbbb 1",
               reg_write, rd, wr_src, write_data, alu_ready);
    end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src, write_data} !== {1'b1, 5'd3, 1'b0, 32'h0000_AAAA}) begin
      fails++;
      $display("FAIL contend_alu: got we=%b rd=%0d src=%b data=%h, want 1 3 0 aaaa",
               reg_write, rd, wr_src, write_data);
    end
  endtask

  task automatic test_x0();
    @(posedge clk); #1;
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h1234_5678;
    @(negedge clk);
    tests++;
    if (ld_ready !== 1'b1) begin
      fails++;
      $display("FAIL x0_ready: got ld_ready=%b, want 1", ld_ready);
    end
    @(posedge clk); #1;
    ld_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src, write_data} !== {1'b0, 5'd0, 1'b1, 32'h1234_5678}) begin
      fails++;
      $display("FAIL x0_drop: got we=%b rd=%0d src=%b data=%h, want 0 0 1 12345678",
               reg_write, rd, wr_src, write_data);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        alu_valid = 1'b1; alu_rd = 5'(i + 1); alu_data = 32'hC0DE_0000 + 32'(i);
      end else begin
        alu_valid = 1'b0;
      end
      if (i > 0) begin
        @(negedge clk);
        tests++;
        if ({reg_write, rd, write_data} !== {1'b1, 5'(i), 32'hC0DE_0000 + 32'(i - 1)}) begin
          fails++;
          $display("FAIL b2b_%0d: got we=%b rd=%0d data=%h, want 1 %0d %h", i, reg_write, rd,
                   write_data, i, 32'hC0DE_0000 + 32'(i - 1));
        end
      end
    end
  endtask

  task automatic test_starvation();
    logic [4:0] exp_ld;
`ifdef RF_WARB_STARVE_GUARD_EN
    exp_ld = 5'b10111;
`else
    exp_ld = 5'b11111;
`endif
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd20; alu_data = 32'h0000_0020;
    ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data  = 32'h0000_0010;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if ({ld_ready, alu_ready} !== {exp_ld[i], !exp_ld[i]}) begin
        fails++;
        $display("FAIL starve_grant_%0d: got ld=%b alu=%b, want %b %b", i, ld_ready, alu_ready,
                 exp_ld[i], !exp_ld[i]);
      end
      if (i > 0) begin
        tests++;
        if ({reg_write, wr_src} !== {1'b1, exp_ld[i-1]}) begin
          fails++;
          $display("FAIL starve_src_%0d: got we=%b src=%b, want 1 %b", i, reg_write, wr_src,
                   exp_ld[i-1]);
        end
      end
`ifdef RF_WARB_STARVE_GUARD_EN
      if (i == 4) begin
        tests++;
        if (dut.starve_q !== 4'd0) begin
          fails++;
          $display("FAIL starve_counter: got %0d, want 0", dut.starve_q);
        end
      end
`endif
      @(posedge clk); #1;
      ld_rd = 5'(11 + i);
    end
    ld_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({wr_src, alu_ready} !== {exp_ld[4], 1'b1}) begin
      fails++;
      $display("FAIL starve_tail: got src=%b alu_ready=%b, want %b 1", wr_src, alu_ready,
               exp_ld[4]);
    end
    @(posedge clk); #1;
    alu_valid = 1'b0;
    @(negedge clk);
    tests++;
    if ({reg_write, rd, wr_src} !== {1'b1, 5'd20, 1'b0}) begin
      fails++;
      $display("FAIL starve_alu_done: got we=%b rd=%0d src=%b, want 1 20 0", reg_write, rd,
               wr_src);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h0BAD_F00D;
    @(posedge clk); #1;
    alu_valid = 1'b0;
    rst = 1'b1;
    #1;
    tests++;
    if ({reg_write, rd, write_data} !== 38'd0) begin
      fails++;
      $display("FAIL reset_mid: got we=%b rd=%0d data=%h, want 0 0 0", reg_write, rd,
               write_data);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (reg_write !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_after: got we=%b, want 0", reg_write);
    end
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'h1;
    ld_valid  = 1'b1; ld_rd  = 5'd2; ld_data  = 32'h2;
    test_reset();
    test_single_alu();
    test_contention();
    test_x0();
    test_back_to_back();
    test_starvation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
